// File: rtl/fn1_mul_pkg.sv
// Shared definitions for the fn1 multiply/MAC pipeline: width helper, parameter bounds
// and the per-stage control word that travels alongside each operand pair.
package fn1_mul_pkg;

    localparam int unsigned DIN0_MIN  = 2;
    localparam int unsigned DIN0_MAX  = 27;
    localparam int unsigned DIN1_MIN  = 2;
    localparam int unsigned DIN1_MAX  = 18;
    localparam int unsigned STAGE_MIN = 3;
    localparam int unsigned STAGE_MAX = 8;

    typedef struct packed {
        logic valid;
        logic acc_en;
    } ctrl_t;

    function automatic int unsigned prod_width(int unsigned w0, int unsigned w1);
        return w0 + w1;
    endfunction

    function automatic bit params_ok(int unsigned w0, int unsigned w1, int unsigned wout,
                                     int unsigned wacc, int unsigned stages);
        return (w0 >= DIN0_MIN) && (w0 <= DIN0_MAX) &&
               (w1 >= DIN1_MIN) && (w1 <= DIN1_MAX) &&
               (wout <= wacc) && (wacc >= prod_width(w0, w1)) &&
               (stages >= STAGE_MIN) && (stages <= STAGE_MAX);
    endfunction

endpackage

// File: rtl/fn1_mul_core.sv
// Operand registers, full-width multiply and product delay chain; a single enable freezes
// everything so the datapath maps onto a DSP slice with its own pipeline registers.
module fn1_mul_core
    import fn1_mul_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 15,
    parameter int unsigned DIN1_WIDTH = 17,
    parameter int unsigned NUM_STAGE  = 4,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              en,
    input  logic [DIN0_WIDTH-1:0]                             a,
    input  logic [DIN1_WIDTH-1:0]                             b,
    output logic [prod_width(DIN0_WIDTH, DIN1_WIDTH)-1:0]     p
);

    localparam int unsigned PW   = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int          NDLY = int'(NUM_STAGE) - 2;

    logic [DIN0_WIDTH-1:0] a_q;
    logic [DIN1_WIDTH-1:0] b_q;
    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         b_ext;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         pipe_q [NDLY];

    // Both operands extended to the product width, so the low PW bits of an unsigned
    // multiply are the exact result for either signedness.
    always_comb begin
        a_ext = PW'(a_q);
        b_ext = PW'(b_q);
        if (SIGNED != 0) begin
            a_ext = PW'($signed(a_q));
            b_ext = PW'($signed(b_q));
        end
        prod = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < NDLY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en) begin
            a_q       <= a;
            b_q       <= b;
            pipe_q[0] <= prod;
            for (int i = 1; i < NDLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign p = pipe_q[NDLY-1];

endmodule

// File: rtl/fn1_mul_acc_pipe.sv
// Pipelined multiply / multiply-accumulate with valid/ready handshake and a global stall.
// The datapath lives in fn1_mul_core; this level carries the control chain and accumulator.
module fn1_mul_acc_pipe
    import fn1_mul_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 15,
    parameter int unsigned DIN1_WIDTH = 17,
    parameter int unsigned DOUT_WIDTH = 31,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned NUM_STAGE  = 4,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int unsigned PW    = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int          CHAIN = int'(NUM_STAGE) - 1;

    if (!params_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, ACC_WIDTH, NUM_STAGE)) begin : g_bad_param
        $error("fn1_mul_acc_pipe: parameter outside supported range");
    end

    logic                 advance;
    ctrl_t                ctrl_in;
    ctrl_t [CHAIN-1:0]    ctrl_q;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 out_valid_q;

    // Stall is global: every stage, including the core, moves only when the output slot
    // is free or being drained.
    assign advance  = ce && (!out_valid_q || out_ready);
    assign in_ready = advance;

    assign ctrl_in = '{valid: in_valid, acc_en: acc_en};

    fn1_mul_core #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .SIGNED     (SIGNED)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .a     (din0),
        .b     (din1),
        .p     (prod)
    );

    always_comb begin
        prod_ext = ACC_WIDTH'(prod);
        if (SIGNED != 0) begin
            prod_ext = ACC_WIDTH'($signed(prod));
        end
    end

    // Bubbles leave the running sum untouched.
    always_comb begin
        acc_d = acc_q;
        if (ctrl_q[CHAIN-1].valid) begin
            acc_d = ctrl_q[CHAIN-1].acc_en ? (acc_q + prod_ext) : prod_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else if (advance) begin
            ctrl_q      <= {ctrl_q[CHAIN-2:0], ctrl_in};
            out_valid_q <= ctrl_q[CHAIN-1].valid;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = acc_q[DOUT_WIDTH-1:0];

endmodule

// File: tb/tb_fn1_mul_acc_pipe.sv
// Scoreboard bench: an unsigned default-parameter instance and a small signed instance,
// both checked against plain-arithmetic accumulator models.
module tb_fn1_mul_acc_pipe;

    localparam int unsigned NS   = 4;
    localparam int unsigned NS_S = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        out_ready;
    logic        in_valid, acc_en, in_ready, out_valid;
    logic [14:0] din0;
    logic [16:0] din1;
    logic [30:0] dout;
    logic        in_valid_s, acc_en_s, in_ready_s, out_valid_s;
    logic [7:0]  din0_s, din1_s;
    logic [15:0] dout_s;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] acc_m = '0;
    logic [47:0] acc_s = '0;
    logic [30:0] q_m[$];
    logic [15:0] q_s[$];
    bit          hit_m;

    always #5 clk = ~clk;

    fn1_mul_acc_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    fn1_mul_acc_pipe #(
        .DIN0_WIDTH (8),
        .DIN1_WIDTH (8),
        .DOUT_WIDTH (16),
        .ACC_WIDTH  (48),
        .NUM_STAGE  (NS_S),
        .SIGNED     (1)
    ) u_dut_s (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .din0      (din0_s),
        .din1      (din1_s),
        .acc_en    (acc_en_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .dout      (dout_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] model_m(logic [14:0] a, logic [16:0] b, logic ae);
        logic [63:0] p;
        p     = 64'(a) * 64'(b);
        acc_m = ae ? acc_m + p[47:0] : p[47:0];
        return acc_m[30:0];
    endfunction

    function automatic logic [15:0] model_s(logic [7:0] a, logic [7:0] b, logic ae);
        longint p;
        p     = longint'($signed(a)) * longint'($signed(b));
        acc_s = ae ? acc_s + 48'(p) : 48'(p);
        return acc_s[15:0];
    endfunction

    // Called at a negedge with inputs already set; records accepted beats, ends at next negedge.
    task automatic tick(input bit stall = 1'b0);
        #1;
        hit_m = 1'b0;
        if (!reset) begin
            check("in_ready_rule", in_ready, ce && (!out_valid || out_ready));
            if (stall) check("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                q_m.push_back(model_m(din0, din1, acc_en));
                hit_m = 1'b1;
            end
            if (in_valid_s && in_ready_s) q_s.push_back(model_s(din0_s, din1_s, acc_en_s));
        end
        @(negedge clk);
    endtask

    // Called at a negedge; returns at negedge+1 with the selected out_valid high or timed out.
    task automatic wait_ov(input bit sel, input string name);
        int n = 0;
        #1;
        while (((sel ? out_valid_s : out_valid) == 1'b0) && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, sel ? out_valid_s : out_valid, 1);
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset && ce && out_valid && out_ready) begin
            if (q_m.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL main_extra: got %0h, expected no output", dout);
            end else begin
                check("main_dout", dout, q_m.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset && ce && out_valid_s && out_ready) begin
            if (q_s.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL signed_extra: got %0h, expected no output", dout_s);
            end else begin
                check("signed_dout", dout_s, q_s.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        int sent;
        int n;
        logic        snap_v;
        logic [30:0] snap_d;

        reset = 1'b1; ce = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; din0 = '0; din1 = '0; acc_en = 1'b0;
        in_valid_s = 1'b0; din0_s = '0; din1_s = '0; acc_en_s = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_out_valid_s", out_valid_s, 0);
        check("rst_dout_s", dout_s, 0);
        check("rst_in_ready_ce0", in_ready, 0);
        ce = 1'b1;
        #1 check("rst_in_ready_ce1", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Max unsigned operands, latency in edges counted from the accepting edge.
        din0 = 15'h7FFF; din1 = 17'h1FFFF; acc_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges = 1;
        #1;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            #1;
            edges++;
        end
        check("latency_edges", edges, NS);
        check("dout_max_unsigned", dout, 31'h7FFD8001);
        @(negedge clk);

        // MAC stream, results on consecutive cycles.
        din0 = 15'd2; din1 = 17'd3; acc_en = 1'b0; in_valid = 1'b1; tick();
        din0 = 15'd4; din1 = 17'd5; acc_en = 1'b1; tick();
        din0 = 15'd1; din1 = 17'd1; acc_en = 1'b0; tick();
        in_valid = 1'b0;
        wait_ov(1'b0, "mac_wait");
        check("mac_0", dout, 6);
        @(negedge clk); #1;
        check("mac_1_valid", out_valid, 1);
        check("mac_1", dout, 26);
        @(negedge clk); #1;
        check("mac_2_valid", out_valid, 1);
        check("mac_2", dout, 1);
        @(negedge clk);

        // Signed -3 * 5.
        din0_s = 8'hFD; din1_s = 8'h05; acc_en_s = 1'b0; in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        wait_ov(1'b1, "signed_wait");
        check("signed_neg15", dout_s, 16'hFFF1);
        @(negedge clk);
        tick(); tick();

        // 8 beats with a 3-cycle consumer stall once the first result is presented.
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 4 && c < 7);
            in_valid  = (sent < 8);
            din0      = 15'($urandom);
            din1      = 17'($urandom);
            acc_en    = 1'($urandom_range(0, 1));
            tick(c >= 4 && c < 7);
            if (hit_m) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_beats_sent", sent, 8);
        tick(); tick();

        // Clock-enable freeze with results in flight.
        for (int i = 0; i < 4; i++) begin
            din0 = 15'($urandom); din1 = 17'($urandom); acc_en = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        ce = 1'b0;
        snap_v = out_valid;
        snap_d = dout;
        check("freeze_has_result", snap_v, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("freeze_valid", out_valid, snap_v);
            check("freeze_dout", dout, snap_d);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Randomised traffic with stalls and clock-enable gaps on both instances.
        for (int c = 0; c < 400; c++) begin
            ce         = ($urandom_range(0, 7) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = 1'($urandom_range(0, 1));
            din0       = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
            din1       = ($urandom_range(0, 7) == 0) ? 17'h1FFFF : 17'($urandom);
            acc_en     = 1'($urandom_range(0, 1));
            in_valid_s = 1'($urandom_range(0, 1));
            din0_s     = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            din1_s     = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            acc_en_s   = 1'($urandom_range(0, 1));
            tick();
        end
        ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset with three beats in flight.
        acc_en = 1'b0; in_valid = 1'b1;
        din0 = 15'h1234; din1 = 17'h00ABC; tick();
        din0 = 15'h0555; din1 = 17'h01111; tick();
        din0 = 15'h0777; din1 = 17'h00222; tick();
        in_valid = 1'b0;
        @(posedge clk);
        #2 check("pre_reset_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_dout", dout, 0);
        q_m.delete();
        q_s.delete();
        acc_m = '0;
        acc_s = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_reset_idle", out_valid, 0);
        end

        // First beat after reset with acc_en=1 adds to zero.
        din0 = 15'd7; din1 = 17'd9; acc_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ov(1'b0, "first_acc_wait");
        check("first_acc_from_zero", dout, 63);
        @(negedge clk);

        ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0;
        n = 0;
        while ((q_m.size() != 0 || q_s.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        tick(); tick();
        check("drain_q_m", q_m.size(), 0);
        check("drain_q_s", q_s.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fn1_mul_acc_pipe.md
# fn1_mul_acc_pipe

Parametrised, pipelined multiply/multiply-accumulate unit with a valid/ready stream interface. It generalises the fixed-width, fixed-latency DSP multiplier to configurable operand widths, signedness and latency. It adds back-pressure handling and an optional running-sum (MAC) mode. It sits between HLS datapath FSMs and downstream consumers that may stall.

## Interface
- DIN0_WIDTH, 15, operand A width (2..27)
- DIN1_WIDTH, 17, operand B width (2..18)
- DOUT_WIDTH, 31, output width; must not exceed ACC_WIDTH
- ACC_WIDTH, 48, accumulator width; must be at least DIN0_WIDTH+DIN1_WIDTH
- NUM_STAGE, 4, accept-to-output latency in cycles (3..8)
- SIGNED, 0, 0 = both operands unsigned; 1 = both two's-complement
---
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  global clock enable; when low, all state freezes
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts a beat this cycle
- din0  in  DIN0_WIDTH  operand A
- din1  in  DIN1_WIDTH  operand B
- acc_en  in  1  sampled with the beat; 1 = add product to the running sum, 0 = start a new sum with this product
- out_valid  out  1  dout holds a result
- out_ready  in  1  consumer takes the result
- dout  out  DOUT_WIDTH  acc[DOUT_WIDTH-1:0]

## Operation
- A beat is accepted when in_valid && in_ready.
- The pipeline runs NUM_STAGE stages, each with a valid bit:
  - stage 1: input registers for din0, din1 and acc_en
  - stages 2..NUM_STAGE-1: product register and delay registers
  - stage NUM_STAGE: accumulator/output register
- advance = ce && (!out_valid || out_ready).
  - When advance is high, every stage shifts by one.
  - When advance is low, every register holds. The stall is global, with no per-stage bubble collapsing.
- in_ready = advance. It is combinational and never depends on in_valid.
- Product: the full DIN0_WIDTH+DIN1_WIDTH-bit result, extended to ACC_WIDTH. Zero-extend when SIGNED=0; sign-extend when SIGNED=1.
- Final stage, when a valid beat arrives there:
  - acc = acc_en ? acc + product : product, wrapping modulo 2^ACC_WIDTH
  - bubbles (invalid beats) leave acc unchanged
- dout is the low DOUT_WIDTH bits of acc, truncated with no saturation.
- out_valid is the final-stage valid bit. It drops when a result is taken and no new valid beat enters the final stage in the same cycle.
- acc_en=1 on the first beat after reset adds to acc=0.

## Timing
- Reset (asynchronous, immediate):
  - all valid bits are 0, so out_valid=0
  - acc=0, so dout=0
  - operand and product registers are 0
  - in_ready follows ce, because out_valid=0
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+NUM_STAGE-1, provided no stall occurs.
- Throughput: one beat per cycle while out_ready=1 and ce=1.
- Result held (out_valid=1, out_ready=0): dout and out_valid are stable, in_ready=0, and no input is lost.
- Result taken and new result arriving in the same cycle: dout updates to the new result and out_valid stays 1.
- ce=0: nothing changes, and in_ready=0 even when out_valid=0.
- Reset mid-stream: in-flight beats are discarded, with no partial results afterwards.

## Structure
- Shared package fn1_mul_pkg:
  - a function computing the product width (DIN0_WIDTH+DIN1_WIDTH)
  - elaboration-check constants for the parameter bounds above
- Sub-module fn1_mul_core: the operand-register → multiply → delay chain, with the enable input driven by advance. It is DSP-inferable and holds no handshake logic.
- The top level holds the valid chain, acc_en delay, accumulator and handshake.

## Test plan
- Unsigned, default parameters, din0=0x7FFF, din1=0x1FFFF, acc_en=0 → dout=0x7FFD8001 (truncated from 0xFFFD8001). out_valid rises after the 4th edge following acceptance.
- SIGNED=1, DIN0=DIN1=8, din0=-3, din1=5, acc_en=0, DOUT=16 → dout=0xFFF1 (-15).
- MAC stream (2,3,acc_en=0), (4,5,1), (1,1,0) back-to-back → outputs 6, 26, 1 on consecutive cycles.
- Stream 8 beats with out_ready held low for 3 cycles mid-stream → in_ready=0 during the stall, all 8 products delivered in order with none dropped or duplicated.
- ce=0 for 2 cycles with beats in flight → all outputs frozen; after resuming, results are identical to an uninterrupted run shifted by 2 cycles.
- Assert reset asynchronously (between edges) with 3 beats in flight → out_valid=0 and dout=0 immediately, and no results appear afterwards.
